id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register, directly downstream of the immediate sign extender.
- Captures the decode-stage operands, the 32-bit sign-extended immediate, the register specifiers and the control word each cycle.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles for them.
- Honours downstream stall and branch-flush requests, and counts inserted bubbles for performance measurement.

Parameters:
- DATA_W, 32, width of register operands and of the sign-extended immediate.
- CTRL_W, 10, width of the opaque EX/MEM/WB control word.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  synchronous reset, active-low.
- ID_Valid  in  1  decode slot holds a real instruction.
- ID_RsData  in  DATA_W  register-file read port A.
- ID_RtData  in  DATA_W  register-file read port B.
- ID_Imm  in  DATA_W  sign-extended immediate from the sign extender.
- ID_Rs  in  5  source register specifier rs.
- ID_Rt  in  5  source register specifier rt.
- ID_Rd  in  5  destination register specifier rd.
- ID_Ctrl  in  CTRL_W  decoded control word.
- ID_MemRead  in  1  decode instruction is a load.
- Stall  in  1  downstream hold request.
- Flush  in  1  branch/jump squash request.
- EX_Valid  out  1  EX slot holds a real instruction.
- EX_RsData  out  DATA_W  registered operand A.
- EX_RtData  out  DATA_W  registered operand B.
- EX_Imm  out  DATA_W  registered immediate.
- EX_Rs  out  5  registered rs.
- EX_Rt  out  5  registered rt.
- EX_Rd  out  5  registered rd.
- EX_Ctrl  out  CTRL_W  registered control word.
- EX_MemRead  out  1  registered load flag.
- HazardStall  out  1  combinational; freezes PC and IF/ID.
- BubbleCount  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Clock and reset: single clock Clk. Synchronous active-low reset Rst_n, sampled on the rising edge.
- Reset values: all registered outputs clear to 0. This includes EX_Valid, EX_MemRead, EX_Ctrl, all data, all specifiers and BubbleCount.
- Reset mid-operation: reset discards any in-flight instruction. No partial state is retained.
- HazardStall definition (combinational, no register stage):
  - HazardStall = EX_Valid & EX_MemRead & ID_Valid & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (EX_Rt == ID_Rt)).
  - It is forced to 0 while Flush=1, because the ID slot is being squashed anyway.
- Per-edge update, in strict priority order:
  1. Rst_n=0: reset.
  2. Flush=1: load a bubble. EX_Valid=0, EX_Ctrl=0, EX_MemRead=0; data and specifier fields are don't-care and are zeroed. Flush overrides Stall.
  3. Stall=1: hold every register unchanged, including EX_Valid. No bubble is counted. HazardStall continues to be evaluated from the held EX state.
  4. HazardStall=1: load a bubble, same encoding as in step 2. The ID instruction is not consumed; IF/ID holds it, so it re-presents next cycle.
  5. Otherwise: load all ID_* fields. EX_Valid <= ID_Valid. If ID_Valid=0, EX_Ctrl and EX_MemRead load 0 regardless of their inputs.
- Latency: exactly 1 cycle from ID inputs to EX outputs when no stall, flush or hazard is active.
- Load-use penalty: exactly one bubble. After the bubble, EX_Valid=0, so HazardStall deasserts and the dependent instruction loads on the next edge.
- Immediate handling: ID_Imm passes through bit-exact. This stage performs no re-extension and no masking.
- BubbleCount:
  - Increments by 1 on each edge taking branch 2 (and only if the slot being squashed had ID_Valid=1) or branch 4.
  - Saturates at all-ones and never wraps.
  - Clears only on reset.
- Register 0 rule: a load whose EX_Rt=0 never raises HazardStall.
- Simultaneous Flush and HazardStall: Flush wins and exactly one bubble is counted.

Test Plan:
- Reset: hold Rst_n=0 for 2 edges with random ID inputs -> all outputs 0, BubbleCount=0. Release, then present ID_Valid=1, ID_Imm=0xFFFF8000, ID_Ctrl=0x155 -> next edge EX_Imm=0xFFFF8000, EX_Ctrl=0x155, EX_Valid=1.
- Load-use: EX holds a load with EX_Rt=8; ID presents ID_Rs=8 -> HazardStall=1 immediately. Next edge EX_Valid=0 and BubbleCount=1. Following edge the dependent instruction loads with EX_Valid=1.
- Register-0 and non-matching cases: EX load with EX_Rt=0 and ID_Rs=0 -> HazardStall=0. EX load with EX_Rt=9 and ID_Rs=8, ID_Rt=10 -> HazardStall=0, normal load.
- Stall hold: set EX contents to RsData=0x12345678, then assert Stall for 3 cycles while changing ID inputs -> EX outputs unchanged all 3 cycles, BubbleCount unchanged.
- Flush priority: Flush=1, Stall=1 and a hazard condition in the same cycle -> next edge EX_Valid=0, EX_Ctrl=0, BubbleCount +1 exactly once, HazardStall=0 during the Flush cycle.
- Saturation: force 2^CNT_W+5 hazard bubbles (CNT_W=4 override -> 21 bubbles) -> BubbleCount stops at 0xF and stays there. Reset returns it to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rd,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic              ID_MemRead,
  input  logic              Stall,
  input  logic              Flush,
  output logic              EX_Valid,
  output logic [DATA_W-1:0] EX_RsData,
  output logic [DATA_W-1:0] EX_RtData,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [4:0]        EX_Rs,
  output logic [4:0]        EX_Rt,
  output logic [4:0]        EX_Rd,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic              EX_MemRead,
  output logic              HazardStall,
  output logic [CNT_W-1:0]  BubbleCount
);

  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] rs_data_reg, rs_data_next;
  logic [DATA_W-1:0] rt_data_reg, rt_data_next;
  logic [DATA_W-1:0] imm_reg, imm_next;
  logic [4:0]        rs_reg, rs_next;
  logic [4:0]        rt_reg, rt_next;
  logic [4:0]        rd_reg, rd_next;
  logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
  logic              mem_read_reg, mem_read_next;
  logic [CNT_W-1:0]  bubble_cnt_reg, bubble_cnt_next;
  logic              hazard;
  logic              count_bubble;

  // A squashed ID slot needs no stall, so Flush masks the hazard outright.
  always_comb begin
    hazard = 1'b0;
    if (!Flush && valid_reg && mem_read_reg && ID_Valid && (rt_reg != 5'd0) &&
        ((rt_reg == ID_Rs) || (rt_reg == ID_Rt)))
      hazard = 1'b1;
  end

  always_comb begin
    valid_next    = valid_reg;
    rs_data_next  = rs_data_reg;
    rt_data_next  = rt_data_reg;
    imm_next      = imm_reg;
    rs_next       = rs_reg;
    rt_next       = rt_reg;
    rd_next       = rd_reg;
    ctrl_next     = ctrl_reg;
    mem_read_next = mem_read_reg;
    count_bubble  = 1'b0;
    if (Flush || (!Stall && hazard)) begin
      valid_next    = 1'b0;
      rs_data_next  = '0;
      rt_data_next  = '0;
      imm_next      = '0;
      rs_next       = '0;
      rt_next       = '0;
      rd_next       = '0;
      ctrl_next     = '0;
      mem_read_next = 1'b0;
      // Flushing an empty slot is not a lost instruction, so it is not counted.
      count_bubble  = Flush ? ID_Valid : 1'b1;
    end else if (!Stall) begin
      valid_next    = ID_Valid;
      rs_data_next  = ID_RsData;
      rt_data_next  = ID_RtData;
      imm_next      = ID_Imm;
      rs_next       = ID_Rs;
      rt_next       = ID_Rt;
      rd_next       = ID_Rd;
      ctrl_next     = ID_Valid ? ID_Ctrl : '0;
      mem_read_next = ID_Valid & ID_MemRead;
    end
  end

  always_comb begin
    bubble_cnt_next = bubble_cnt_reg;
    if (count_bubble && (bubble_cnt_reg != {CNT_W{1'b1}}))
      bubble_cnt_next = bubble_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valid_reg      <= 1'b0;
      rs_data_reg    <= '0;
      rt_data_reg    <= '0;
      imm_reg        <= '0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      rd_reg         <= '0;
      ctrl_reg       <= '0;
      mem_read_reg   <= 1'b0;
      bubble_cnt_reg <= '0;
    end else begin
      valid_reg      <= valid_next;
      rs_data_reg    <= rs_data_next;
      rt_data_reg    <= rt_data_next;
      imm_reg        <= imm_next;
      rs_reg         <= rs_next;
      rt_reg         <= rt_next;
      rd_reg         <= rd_next;
      ctrl_reg       <= ctrl_next;
      mem_read_reg   <= mem_read_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  assign EX_Valid    = valid_reg;
  assign EX_RsData   = rs_data_reg;
  assign EX_RtData   = rt_data_reg;
  assign EX_Imm      = imm_reg;
  assign EX_Rs       = rs_reg;
  assign EX_Rt       = rt_reg;
  assign EX_Rd       = rd_reg;
  assign EX_Ctrl     = ctrl_reg;
  assign EX_MemRead  = mem_read_reg;
  assign HazardStall = hazard;
  assign BubbleCount = bubble_cnt_reg;

endmodule
